// File: rtl/sram_port_arbiter.sv
// Shares the single SRAM_Controller port among N clients via req/grant (fixed or round-robin, burst preemption).
// Grant latency 1 cycle; read data is tagged to the issuing client READ_LATENCY cycles after the address is issued.
module sram_port_arbiter #(
  parameter int N_CLIENTS      = 4,
  parameter int ADDR_W         = 18,
  parameter int DATA_W         = 16,
  parameter int READ_LATENCY   = 2,
  parameter int MAX_BURST      = 64,
  parameter int DEFAULT_CLIENT = 0
) (
  input  logic                          CLOCK_50_I,
  input  logic                          resetn,
  input  logic                          arb_mode_rr,
  input  logic [N_CLIENTS-1:0]          client_req,
  input  logic [N_CLIENTS*ADDR_W-1:0]   client_address,
  input  logic [N_CLIENTS*DATA_W-1:0]   client_write_data,
  input  logic [N_CLIENTS-1:0]          client_we_n,
  output logic [N_CLIENTS-1:0]          client_grant,
  output logic [N_CLIENTS-1:0]          client_rd_valid,
  output logic [N_CLIENTS-1:0]          conflict_flag,
  input  logic                          conflict_clear,
  output logic [2:0]                    owner_id,
  output logic                          bus_busy,
  output logic [ADDR_W-1:0]             SRAM_address,
  output logic [DATA_W-1:0]             SRAM_write_data,
  output logic                          SRAM_we_n,
  input  logic [DATA_W-1:0]             SRAM_read_data
);

  localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);

  typedef enum logic {S_IDLE, S_OWNED} state_t;

  state_t               state_q, state_d;
  logic [2:0]           owner_q, owner_d;
  logic [2:0]           last_q, last_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic [N_CLIENTS-1:0] grant_q, grant_d;
  logic [N_CLIENTS-1:0] others;
  logic [3:0]           pick_all, pick_oth, win;
  logic [2:0]           rr_start;
  logic                 preempt, hold;

  logic                 own_req, own_we_n;
  logic [ADDR_W-1:0]    own_addr;
  logic [DATA_W-1:0]    own_wdata;

  logic [READ_LATENCY-1:0] pipe_vld;
  logic [2:0]              pipe_id [READ_LATENCY];
  logic                    rd_push;

  // Read data is broadcast to clients outside this block.
  logic unused_rd_data;
  assign unused_rd_data = ^SRAM_read_data;

  // Returns {found, index}; round-robin rotates the candidates so the search begins at start.
  function automatic logic [3:0] pick(input logic [N_CLIENTS-1:0] cand, input logic rr,
                                      input logic [2:0] start);
    logic [2*N_CLIENTS-1:0] dbl;
    logic [N_CLIENTS-1:0]   rot;
    logic [3:0]             pos, idx;
    logic                   found;
    dbl   = {cand, cand} >> (rr ? start : 3'd0);
    rot   = dbl[N_CLIENTS-1:0];
    found = 1'b0;
    pos   = 4'd0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        pos   = 4'(k);
      end
    end
    idx = pos + (rr ? {1'b0, start} : 4'd0);
    if (idx >= 4'(N_CLIENTS)) idx = idx - 4'(N_CLIENTS);
    return {found, idx[2:0]};
  endfunction

  always_comb begin
    own_req   = 1'b0;
    own_we_n  = 1'b1;
    own_addr  = '0;
    own_wdata = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (owner_q == 3'(i)) begin
        own_req   = client_req[i];
        own_we_n  = client_we_n[i];
        own_addr  = client_address[i*ADDR_W +: ADDR_W];
        own_wdata = client_write_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign rr_start = (last_q == 3'(N_CLIENTS - 1)) ? 3'd0 : last_q + 3'd1;
  assign others   = client_req & ~grant_q;
  assign pick_all = pick(client_req, arb_mode_rr, rr_start);
  assign pick_oth = pick(others, arb_mode_rr, rr_start);
  // Counter saturates, so a waiter arriving after the limit still forces a handover.
  assign preempt  = (MAX_BURST != 0) && (burst_q >= BURST_LAST) && (|others);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    burst_d = burst_q;
    grant_d = grant_q;
    win     = (state_q == S_OWNED) ? pick_oth : pick_all;
    hold    = (state_q == S_OWNED) && own_req && !preempt;
    if (hold) begin
      burst_d = (&burst_q) ? burst_q : burst_q + 1'b1;
    end else if (win[3]) begin
      state_d = S_OWNED;
      owner_d = win[2:0];
      last_d  = win[2:0];
      burst_d = '0;
      grant_d = {{(N_CLIENTS-1){1'b0}}, 1'b1} << win[2:0];
    end else begin
      state_d = S_IDLE;
      grant_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      owner_q <= 3'd0;
      last_q  <= 3'(N_CLIENTS - 1);
      burst_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      grant_q <= grant_d;
    end
  end

  assign client_grant = grant_q;
  assign bus_busy     = (state_q == S_OWNED);
  assign owner_id     = owner_q;

  always_comb begin
    if (state_q == S_OWNED) begin
      SRAM_address    = own_addr;
      SRAM_write_data = own_wdata;
      SRAM_we_n       = own_we_n | ~own_req;
    end else begin
      SRAM_address    = client_address[DEFAULT_CLIENT*ADDR_W +: ADDR_W];
      SRAM_write_data = '0;
      SRAM_we_n       = 1'b1;
    end
  end

  assign rd_push = (state_q == S_OWNED) && own_req && own_we_n;

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      pipe_vld <= '0;
      for (int s = 0; s < READ_LATENCY; s++) pipe_id[s] <= 3'd0;
    end else begin
      for (int s = READ_LATENCY - 1; s > 0; s--) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_id[s]  <= pipe_id[s-1];
      end
      pipe_vld[0] <= rd_push;
      pipe_id[0]  <= owner_q;
    end
  end

  always_comb begin
    client_rd_valid = '0;
    for (int i = 0; i < N_CLIENTS; i++)
      client_rd_valid[i] = pipe_vld[READ_LATENCY-1] && (pipe_id[READ_LATENCY-1] == 3'(i));
  end

  // A new conflict in the same cycle as a clear keeps its flag.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) conflict_flag <= '0;
    else         conflict_flag <= (conflict_flag & ~{N_CLIENTS{conflict_clear}})
                                  | (client_req & ~client_we_n & ~grant_q);
  end

endmodule
